// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin Wishbone arbiter sharing one RAM slave port
// between NUM_MASTERS requesters. A grant is held for the whole bus cycle
// (while the owner's cyc stays high). One idle cycle separates owners.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort cycles whose slave
// never acknowledges within TIMEOUT_CYCLES strobed cycles.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int SW = DW / 8;
  localparam int LW = $clog2(NUM_MASTERS);

  // Reject out-of-range configurations at elaboration.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("wb_ram_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT_CYCLES 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic                   owner_cyc;
  logic                   found;
  int                     win_idx;

  // cyc of the current owner; zero when nobody is granted.
  assign owner_cyc = |(m_cyc_i & grant_q);
  assign grant_o   = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_hit;

  assign timeout_hit = (state_q == BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES));
`endif

  // State, grant and rotation pointer registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state: rotating search from last+1 in IDLE, hold while owner's cyc is high.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    found   = 1'b0;
    win_idx = 0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_MASTERS; k++) begin
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && int'(last_q) == i && m_cyc_i[(i + k) % NUM_MASTERS]) begin
              found   = 1'b1;
              win_idx = (i + k) % NUM_MASTERS;
            end
          end
        end
        if (found) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << win_idx;
          last_d  = LW'(win_idx);
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ABORT;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (s_stb_o) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Bus routing: owner's request to the RAM, RAM's response to the owner only.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == BUSY) begin
      s_cyc_o = owner_cyc;
      s_stb_o = |(m_stb_i & grant_q);
      s_we_o  = |(m_we_i & grant_q);
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_q[i]) begin
          s_sel_o = m_sel_i[i*SW +: SW];
          s_adr_o = m_adr_i[i*AW +: AW];
          s_dat_o = m_dat_i[i*DW +: DW];
        end
      end
      m_dat_o = s_dat_i;
      m_ack_o = s_ack_i ? grant_q : '0;
`ifdef WB_ARB_TIMEOUT_EN
      if (timeout_hit) begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = grant_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with two masters and a small RAM model
// that acks one cycle after each strobe (and can be stalled).
module tb_wb_ram_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*SW-1:0] m_sel;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]    s_sel_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [DW-1:0]    ram_dat;
  logic             ram_ack;
  logic             ram_stall;

  wb_ram_arbiter #(
    .NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(ram_dat), .s_ack_i(ram_ack),
    .grant_o(grant_o)
  );

  // RAM model: registered ack one cycle after a strobe, byte-lane writes.
  logic [DW-1:0] mem [0:255];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ack <= 1'b0;
      ram_dat <= '0;
    end else begin
      ram_ack <= s_cyc_o && s_stb_o && !ram_ack && !ram_stall;
      if (s_cyc_o && s_stb_o && !ram_ack && !ram_stall) begin
        if (s_we_o) mem[s_adr_o[9:2]] <= merge(mem[s_adr_o[9:2]], s_dat_o, s_sel_o);
        else        ram_dat <= mem[s_adr_o[9:2]];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    m_cyc[m]           = c;
    m_stb[m]           = s;
    m_we[m]            = w;
    m_sel[m*SW +: SW]  = 4'hF;
    m_adr[m*AW +: AW]  = a;
    m_dat[m*DW +: DW]  = d;
  endtask

  task automatic wait_ack(input int m, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (m_ack_o[m]) ok = 1'b1;
    end
    check($sformatf("ack_m%0d", m), 64'(ok), 64'd1);
  endtask

  task automatic wait_grant(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (grant_o != '0) ok = 1'b1;
    end
    check("grant_wait", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [1:0] exp_g;
    bit         bad;
    int         pulses;
    int         err_at;

    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    ram_stall = 1'b0;

    // Reset state.
    #2;
    check("rst_grant", grant_o, 0);
    check("rst_scyc",  s_cyc_o, 0);
    check("rst_ack",   m_ack_o, 0);
    check("rst_err",   m_err_o, 0);
    check("rst_mdat",  m_dat_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single master write then read-back, one-cycle arbitration latency.
    set_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF);
    check("lat_idle_scyc", s_cyc_o, 0);
    tick();
    check("lat_grant", grant_o, 2'b01);
    check("lat_scyc",  s_cyc_o, 1);
    check("wr_adr",    s_adr_o, 32'h100);
    wait_ack(0, 4);
    set_m(0, 0, 0, 0, 0, 0);
    tick();
    check("wr_release", grant_o, 0);
    set_m(0, 1, 1, 0, 32'h100, 0);
    tick();
    wait_ack(0, 4);
    check("rd_data", m_dat_o, 32'hDEADBEEF);
    set_m(0, 0, 0, 0, 0, 0);
    tick();

    // Simultaneous requests straight out of reset: master 0 first, master 1 at M+1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(0, 1, 1, 0, 32'h100, 0);
    set_m(1, 1, 1, 0, 32'h104, 0);
    tick();
    check("sim_first", grant_o, 2'b01);
    wait_ack(0, 4);
    check("sim_no_ack1", m_ack_o[1], 0);
    check("sim_rd_data", m_dat_o, 32'hDEADBEEF);
    set_m(0, 0, 0, 0, 0, 0);
    tick();
    check("sim_dead", grant_o, 0);
    check("sim_dead_scyc", s_cyc_o, 0);
    tick();
    check("sim_second", grant_o, 2'b10);
    wait_ack(1, 4);
    set_m(1, 0, 0, 0, 0, 0);
    tick();

    // Continuous requests from both: grants alternate, acks only to the owner.
    set_m(0, 1, 1, 0, 32'h100, 0);
    set_m(1, 1, 1, 0, 32'h104, 0);
    for (int it = 0; it < 4; it++) begin
      exp_g = (it % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant(4);
      check($sformatf("alt_grant%0d", it), grant_o, exp_g);
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if ((m_ack_o & ~exp_g) != '0) bad = 1'b1;
        tick();
      end
      check($sformatf("alt_ack%0d", it), 64'(bad), 0);
      set_m(it % 2, 0, 0, 0, 0, 0);
      tick();
      check($sformatf("alt_dead%0d", it), grant_o, 0);
      if (it < 3) set_m(it % 2, 1, 1, 0, 32'h100 + 32'(4 * (it % 2)), 0);
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();

    // Master 1 holds cyc for 4 beats while master 0 waits.
    set_m(1, 1, 1, 1, 32'h300, 32'h11110000);
    tick();
    check("burst_grant", grant_o, 2'b10);
    set_m(0, 1, 1, 0, 32'h100, 0);
    for (int b = 0; b < 4; b++) begin
      wait_ack(1, 4);
      check($sformatf("burst_own%0d", b), grant_o, 2'b10);
      set_m(1, 1, 1, 1, 32'h300 + 32'(4 * (b + 1)), 32'h11110000 + 32'(b + 1));
    end
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    check("burst_dead", grant_o, 0);
    tick();
    check("burst_next", grant_o, 2'b01);

    // Reset mid-burst: outputs clear before the next edge; master 0 wins again.
    set_m(1, 1, 1, 0, 32'h104, 0);
    tick();
    check("mid_owner", grant_o, 2'b01);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_grant", grant_o, 0);
    check("mid_rst_scyc",  s_cyc_o, 0);
    check("mid_rst_sstb",  s_stb_o, 0);
    check("mid_rst_sadr",  s_adr_o, 0);
    check("mid_rst_ack",   m_ack_o, 0);
    check("mid_rst_mdat",  m_dat_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_rewin", grant_o, 2'b01);
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    check("mid_idle", grant_o, 0);

    // Stalled slave: watchdog (if built in) aborts, otherwise the bus is held.
    ram_stall = 1'b1;
    set_m(1, 1, 1, 0, 32'h104, 0);
    tick();
    check("stall_grant", grant_o, 2'b10);
    set_m(0, 1, 1, 0, 32'h100, 0);
    pulses = 0;
    err_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (m_err_o[1]) begin
        pulses++;
        err_at = i;
        check("abort_sstb", s_stb_o, 0);
      end
    end
    check("stall_err0", m_err_o[0], 0);
    check("stall_hold", grant_o, 2'b10);
`ifdef WB_ARB_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_err_at", err_at, 8);
    check("to_abort_scyc", s_cyc_o, 0);
`else
    check("stall_pulses", pulses, 0);
    check("stall_scyc", s_cyc_o, 1);
`endif
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    check("stall_release", grant_o, 0);
    tick();
    check("stall_next", grant_o, 2'b01);
    ram_stall = 1'b0;
    wait_ack(0, 4);
    set_m(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Round-robin Wishbone arbiter that shares the single-ported `ram_wb` SRAM between up to four Wishbone masters, e.g. the AXI4-Lite bridge, a DMA engine and a memory scrubber. It sits between the masters and the RAM's Wishbone slave port. It grants one master for a complete bus cycle, locked while that master's `cyc` stays high, and routes the RAM's data and `ack` back to that master only. An optional watchdog aborts slave cycles that never acknowledge.

## Interface
- `NUM_MASTERS`, default 2: number of requesters, legal range 2..4.
- `AW`, default 32: address width.
- `DW`, default 32: data width; `SW = DW/8` select bits.
- `TIMEOUT_CYCLES`, default 255: watchdog limit, legal range 1..65535. Used only when `WB_ARB_TIMEOUT_EN` is defined.
- `clk_i`, in, 1: the one clock; all state updates on its rising edge.
- `rst_i`, in, 1: reset; asynchronous assert, active-high.
- `m_cyc_i`, in, NUM_MASTERS: per-master `cyc`.
- `m_stb_i`, in, NUM_MASTERS: per-master `stb`.
- `m_we_i`, in, NUM_MASTERS: per-master write enable.
- `m_sel_i`, in, NUM_MASTERS*SW: packed byte selects; master i occupies slice [i*SW +: SW].
- `m_adr_i`, in, NUM_MASTERS*AW: packed addresses.
- `m_dat_i`, in, NUM_MASTERS*DW: packed write data.
- `m_dat_o`, out, DW: read data, broadcast to all masters and valid only with that master's `ack`.
- `m_ack_o`, out, NUM_MASTERS: per-master `ack`.
- `m_err_o`, out, NUM_MASTERS: per-master `err`, used only by the watchdog.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, out, 1 each: to the RAM.
- `s_sel_o` (out, SW), `s_adr_o` (out, AW), `s_dat_o` (out, DW): to the RAM.
- `s_dat_i` (in, DW), `s_ack_i` (in, 1): from the RAM.
- `grant_o`, out, NUM_MASTERS: one-hot current owner, for status and debug.

## Operation
- State machine: IDLE, BUSY, ABORT. Registers: `state`, `grant` (one-hot), `last` (index of the most recent owner), and the watchdog counter when enabled.
- Reset values:
  - `state` = IDLE, `grant` = 0, `last` = NUM_MASTERS-1, so master 0 wins first.
  - All outputs are 0: `s_*`, `m_ack_o`, `m_err_o`, `grant_o`, `m_dat_o`.
- IDLE:
  - If any `m_cyc_i` is set, grant the first requester found searching `last+1, last+2, …` modulo NUM_MASTERS.
  - Set `grant`, update `last`, and go to BUSY.
  - With no requests, stay in IDLE.
- BUSY:
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_adr_o` and `s_dat_o` are combinationally muxed from the granted master.
  - `m_ack_o[g] = s_ack_i`; every other `m_ack_o` bit is 0.
  - `m_dat_o = s_dat_i`.
  - Ownership persists across any number of `stb`/`ack` beats while `m_cyc_i[g]` = 1. Other requests wait and are never dropped.
  - When `m_cyc_i[g]` is sampled 0: `grant` goes to 0 and `state` to IDLE.
- Outside BUSY, all `s_*` outputs are driven 0 and every `m_ack_o` bit is 0.
- Requests that arrive simultaneously are resolved purely by rotation. No master can win twice in a row while another master is requesting.
- A master that drops `cyc` before it is granted withdraws its request; no state is kept for it.
- Reset asserted mid-cycle: all outputs go to 0 immediately (asynchronously). An in-flight RAM access is abandoned.

## Timing
- Arbitration latency: `m_cyc_i` sampled high at edge N in IDLE gives `grant_o` and `s_cyc_o` high after edge N.
- The RAM's own ack latency then adds directly; the arbiter inserts no further registers on the data or ack path.
- Release: `m_cyc_i[g]` sampled low at edge M gives IDLE after M. The next owner is granted at edge M+1, so there is exactly one dead cycle between owners.
- Back-to-back beats within one grant have zero added latency.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on grant and on each `s_ack_i`, and increments while `s_stb_o`=1 and `s_ack_i`=0.
  - When it reaches TIMEOUT_CYCLES: `m_err_o[g]` pulses for 1 cycle, `s_cyc_o`/`s_stb_o` drop, and the state moves to ABORT.
  - ABORT holds `grant` and keeps all `s_*` outputs at 0 until `m_cyc_i[g]` = 0, then goes to IDLE.
- Not defined:
  - No counter, ABORT is unreachable, and `m_err_o` is tied to 0.
  - A stalled slave holds the bus indefinitely.

## Test plan
- Single master 0 writes 0xDEADBEEF to 0x100, then reads it back. Required: `s_cyc_o` high one cycle after `m_cyc_i[0]`, and read `m_dat_o` = 0xDEADBEEF with `m_ack_o[0]`.
- Masters 0 and 1 request in the same cycle straight out of reset. Required: master 0 is granted first; master 1 is granted at exactly M+1 after master 0 releases at edge M.
- Both masters request continuously for 6 cycles each. Required: grants alternate 0,1,0,1… and `m_ack_o[1]` never asserts during master 0's grant.
- Master 1 holds `cyc` across 4 `stb`/`ack` beats while master 0 requests. Required: master 0 is not granted until all 4 beats finish and master 1's `cyc` falls.
- Reset asserted mid-burst. Required: all outputs are 0 before the next clock edge; after release, master 0 wins again.
- With `WB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, the RAM `ack` is stuck low. Required: `m_err_o[g]` pulses once, 8 cycles after `stb`; the arbiter stays in ABORT until that master's `cyc` falls, then serves the other master.
